// File: rtl/jtag_bus_bridge_if.sv
// Bundle of the debug-side request/response handshake and the system-bus master port.
//   master : the bridge's view. It takes debug requests and drives bus requests.
//   slave  : the environment's view. That is the debug module plus the interconnect.
// Signal names keep their direction suffix as seen from the bridge.
interface jtag_bus_bridge_if;
  // Debug request channel
  logic        dbg_req_valid_i;
  logic        dbg_req_ready_o;
  logic        dbg_we_i;
  logic [31:0] dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic [1:0]  dbg_size_i;
  // Debug response channel
  logic        dbg_resp_valid_o;
  logic        dbg_resp_ready_i;
  logic [31:0] dbg_resp_rdata_o;
  logic        dbg_resp_err_o;
  // System-bus master port
  logic        m_req_o;
  logic        m_gnt_i;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_be_o;
  logic        m_rvalid_i;
  logic [31:0] m_rdata_i;
  logic        m_err_i;

  modport master (
    input  dbg_req_valid_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_size_i,
    output dbg_req_ready_o,
    input  dbg_resp_ready_i,
    output dbg_resp_valid_o, dbg_resp_rdata_o, dbg_resp_err_o,
    output m_req_o, m_we_o, m_addr_o, m_wdata_o, m_be_o,
    input  m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i
  );

  modport slave (
    output dbg_req_valid_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_size_i,
    input  dbg_req_ready_o,
    output dbg_resp_ready_i,
    input  dbg_resp_valid_o, dbg_resp_rdata_o, dbg_resp_err_o,
    input  m_req_o, m_we_o, m_addr_o, m_wdata_o, m_be_o,
    output m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i
  );
endinterface

// File: rtl/jtag_bus_bridge.sv
// Turns one debug memory request into one system-bus master transaction.
// The bridge keeps a single access outstanding. It steers byte lanes and checks alignment.
// A cycle budget covers the request and data phases; if it runs out, the access aborts with an error.
// Ports:
//   clk            : rising-edge system clock
//   rst_n          : asynchronous active-low reset
//   bus (master)   : debug request/response channels and the bus master port
// Parameters:
//   TIMEOUT_CYCLES : number of cycles allowed in REQ plus WAIT before the access aborts (1..65535)
module jtag_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  jtag_bus_bridge_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  // The counter is cleared on accept. This value marks the last cycle the budget allows.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_illegal;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] rd_shift;
  logic [31:0] rd_fmt;
  logic        timeout;

  // Lane steering and legality of the incoming request
  always_comb begin
    req_illegal = 1'b0;
    req_be      = 4'b0000;
    req_wdata   = bus.dbg_wdata_i;
    case (bus.dbg_size_i)
      2'd0: begin
        req_be    = 4'b0001 << bus.dbg_addr_i[1:0];
        req_wdata = {4{bus.dbg_wdata_i[7:0]}};
      end
      2'd1: begin
        req_be      = 4'b0011 << bus.dbg_addr_i[1:0];
        req_wdata   = {2{bus.dbg_wdata_i[15:0]}};
        req_illegal = bus.dbg_addr_i[0];
      end
      2'd2: begin
        req_be      = 4'b1111;
        req_illegal = |bus.dbg_addr_i[1:0];
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // Right-justify and zero-extend the addressed lanes of the returned word
  always_comb begin
    rd_shift = bus.m_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'd0:    rd_fmt = {24'h0, rd_shift[7:0]};
      2'd1:    rd_fmt = {16'h0, rd_shift[15:0]};
      default: rd_fmt = rd_shift;
    endcase
  end

  assign timeout = (cnt_q == TimeoutLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.dbg_req_valid_i) begin
          we_d    = bus.dbg_we_i;
          size_d  = bus.dbg_size_i;
          off_d   = bus.dbg_addr_i[1:0];
          addr_d  = {bus.dbg_addr_i[31:2], 2'b00};
          wdata_d = req_wdata;
          be_d    = req_be;
          rdata_d = '0;
          cnt_d   = '0;
          // Illegal requests never touch the bus
          err_d   = req_illegal;
          state_d = req_illegal ? StResp : StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_q + 16'd1;
        // Timeout wins over a grant in the same cycle
        if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else if (bus.m_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        // Completion wins over a coincident timeout, and its data is kept
        if (bus.m_rvalid_i) begin
          err_d   = bus.m_err_i;
          rdata_d = (we_q || bus.m_err_i) ? 32'h0 : rd_fmt;
          state_d = StResp;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.dbg_resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.dbg_req_ready_o  = (state_q == StIdle);
  assign bus.dbg_resp_valid_o = (state_q == StResp);
  assign bus.dbg_resp_rdata_o = rdata_q;
  assign bus.dbg_resp_err_o   = err_q;
  assign bus.m_req_o          = (state_q == StReq);
  assign bus.m_we_o           = we_q;
  assign bus.m_addr_o         = addr_q;
  assign bus.m_wdata_o        = wdata_q;
  assign bus.m_be_o           = be_q;

endmodule

// File: tb/tb_jtag_bus_bridge.sv
// Bench for jtag_bus_bridge. It runs directed accesses followed by random ones.
// Expected results come from a transaction-level model: lane arithmetic plus a cycle budget.
module tb_jtag_bus_bridge;
  localparam int unsigned To = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errs = 0;

  jtag_bus_bridge_if bus ();

  jtag_bus_bridge #(.TIMEOUT_CYCLES(To)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic bit m_illegal(input logic [1:0] size, input logic [31:0] addr);
    int unsigned nb = 1 << size;
    return (size == 2'd3) || ((addr % nb) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input int unsigned off);
    int unsigned nb = 1 << size;
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nb);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    int unsigned nb = 1 << size;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] size, input int unsigned off,
                                          input logic [31:0] bus_word);
    logic [31:0] v = bus_word >> (8 * off);
    if (size == 2'd0) v = v % 256;
    else if (size == 2'd1) v = v % 65536;
    return v;
  endfunction

  // One full access. g = REQ cycles to wait before granting. r = WAIT cycles before rvalid.
  // hold = cycles of response backpressure.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] size, input int g, input int r,
                        input logic [31:0] brd, input logic berr, input int hold);
    int unsigned off = addr % 4;
    int exp_req, total, lat, reqc, waitc;
    logic exp_err;
    logic [31:0] exp_rd;
    bit done;
    if (m_illegal(size, addr)) begin
      exp_req = 0; total = 0; exp_err = 1'b1; exp_rd = '0;
    end else if (g + 1 >= int'(To)) begin
      exp_req = To; total = To; exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_req = g + 1;
      total   = g + 2 + r;
      if (total > int'(To)) begin
        total = To; exp_err = 1'b1; exp_rd = '0;
      end else begin
        exp_err = berr;
        exp_rd  = (we || berr) ? 32'h0 : m_rdata(size, off, brd);
      end
    end

    check("req_ready_idle", {31'h0, bus.dbg_req_ready_o}, 32'h1);
    bus.dbg_req_valid_i = 1'b1;
    bus.dbg_we_i        = we;
    bus.dbg_addr_i      = addr;
    bus.dbg_wdata_i     = wd;
    bus.dbg_size_i      = size;
    @(posedge clk); #1;
    bus.dbg_req_valid_i = 1'b0;
    bus.dbg_addr_i      = $urandom;
    bus.dbg_wdata_i     = $urandom;
    lat = 1; reqc = 0; waitc = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (bus.dbg_resp_valid_o) begin
        done = 1;
      end else begin
        if (bus.m_req_o) begin
          reqc++;
          if (reqc == 1) begin
            check("m_addr", bus.m_addr_o, addr - off);
            check("m_be", {28'h0, bus.m_be_o}, {28'h0, m_be(size, off)});
            check("m_wdata", bus.m_wdata_o, m_wdata(size, wd));
            check("m_we", {31'h0, bus.m_we_o}, {31'h0, we});
          end
          bus.m_gnt_i    = (reqc == g + 1);
          bus.m_rvalid_i = 1'b0;
        end else begin
          waitc++;
          bus.m_gnt_i    = 1'b0;
          bus.m_rvalid_i = (waitc == r + 1);
        end
        bus.m_rdata_i = bus.m_rvalid_i ? brd : $urandom;
        bus.m_err_i   = bus.m_rvalid_i ? berr : 1'($urandom);
        @(posedge clk); #1;
        lat++;
        bus.m_gnt_i    = 1'b0;
        bus.m_rvalid_i = 1'b0;
      end
    end
    if (!done) check("resp_bound", 32'h0, 32'h1);
    check("req_cycles", reqc, exp_req);
    check("latency", lat, total + 1);
    check("resp_rdata", bus.dbg_resp_rdata_o, exp_rd);
    check("resp_err", {31'h0, bus.dbg_resp_err_o}, {31'h0, exp_err});
    check("busy_flags", {30'h0, bus.dbg_req_ready_o, bus.m_req_o}, 32'h0);

    bus.dbg_resp_ready_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_flags", {29'h0, bus.dbg_resp_valid_o, bus.dbg_req_ready_o, bus.dbg_resp_err_o},
            {29'h0, 1'b1, 1'b0, exp_err});
      check("hold_rdata", bus.dbg_resp_rdata_o, exp_rd);
    end
    bus.dbg_resp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.dbg_resp_ready_i = 1'b0;
    check("post_handshake", {30'h0, bus.dbg_resp_valid_o, bus.dbg_req_ready_o}, 32'h1);
  endtask

  initial begin
    logic        rwe;
    logic [1:0]  rsz;
    logic [31:0] raddr;
    int          rg;

    bus.dbg_req_valid_i  = 1'b0;
    bus.dbg_we_i         = 1'b0;
    bus.dbg_addr_i       = '0;
    bus.dbg_wdata_i      = '0;
    bus.dbg_size_i       = '0;
    bus.dbg_resp_ready_i = 1'b0;
    bus.m_gnt_i          = 1'b0;
    bus.m_rvalid_i       = 1'b0;
    bus.m_rdata_i        = '0;
    bus.m_err_i          = 1'b0;

    #1;
    check("rst_flags", {26'h0, bus.dbg_req_ready_o, bus.dbg_resp_valid_o, bus.m_req_o,
                        bus.m_we_o, bus.dbg_resp_err_o, 1'b0}, 32'h20);
    check("rst_be", {28'h0, bus.m_be_o}, 32'h0);
    check("rst_addr", bus.m_addr_o, 32'h0);
    check("rst_wdata", bus.m_wdata_o, 32'h0);
    check("rst_rdata", bus.dbg_resp_rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    access(1'b0, 32'h1000_0008, 32'h0, 2'd2, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);
    access(1'b1, 32'h2000_0003, 32'h5A, 2'd0, 0, 0, 32'h1111_2222, 1'b0, 0);
    access(1'b0, 32'h0000_0102, 32'h0, 2'd1, 1, 1, 32'hABCD_1234, 1'b0, 0);
    access(1'b0, 32'h0000_0001, 32'h0, 2'd2, 0, 0, 32'h0, 1'b0, 0);
    access(1'b0, 32'h0000_0000, 32'h0, 2'd3, 0, 0, 32'h0, 1'b0, 0);
    access(1'b0, 32'h0000_0040, 32'h0, 2'd2, 20, 0, 32'h0, 1'b0, 0);
    // Late grant/completion arriving while idle must be ignored
    bus.m_gnt_i    = 1'b1;
    bus.m_rvalid_i = 1'b1;
    @(posedge clk); #1;
    bus.m_gnt_i    = 1'b0;
    bus.m_rvalid_i = 1'b0;
    check("stray_ignored", {29'h0, bus.dbg_req_ready_o, bus.dbg_resp_valid_o, bus.m_req_o},
          32'h4);
    access(1'b0, 32'h0000_0044, 32'h0, 2'd2, 7, 0, 32'h5555_5555, 1'b0, 0);
    access(1'b0, 32'h0000_0049, 32'h0, 2'd0, 0, 6, 32'h00C3_0000, 1'b0, 0);
    access(1'b0, 32'h0000_004C, 32'h0, 2'd2, 0, 7, 32'h7777_7777, 1'b0, 0);
    access(1'b0, 32'h0000_0050, 32'h0, 2'd2, 1, 2, 32'h9999_9999, 1'b1, 0);
    access(1'b0, 32'h0000_0056, 32'h0, 2'd1, 0, 1, 32'h8765_4321, 1'b0, 5);

    // Random accesses
    for (int n = 0; n < 40; n++) begin
      rwe   = 1'($urandom);
      rsz   = 2'($urandom_range(0, 3));
      raddr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'd1) raddr[0] = 1'b0;
        if (rsz == 2'd2) raddr[1:0] = 2'b00;
      end
      rg = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 3));
      access(rwe, raddr, $urandom, rsz, rg, int'($urandom_range(0, 5)), $urandom,
             ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)));
    end

    // Asynchronous reset while in WAIT
    bus.dbg_req_valid_i = 1'b1;
    bus.dbg_we_i        = 1'b1;
    bus.dbg_addr_i      = 32'h3000_0004;
    bus.dbg_wdata_i     = 32'hCAFE_F00D;
    bus.dbg_size_i      = 2'd2;
    @(posedge clk); #1;
    bus.dbg_req_valid_i = 1'b0;
    bus.m_gnt_i         = 1'b1;
    @(posedge clk); #1;
    bus.m_gnt_i = 1'b0;
    check("in_wait", {30'h0, bus.m_req_o, bus.dbg_resp_valid_o}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_flags", {26'h0, bus.dbg_req_ready_o, bus.dbg_resp_valid_o, bus.m_req_o,
                         bus.m_we_o, bus.dbg_resp_err_o, 1'b0}, 32'h20);
    check("arst_be", {28'h0, bus.m_be_o}, 32'h0);
    check("arst_addr", bus.m_addr_o, 32'h0);
    check("arst_wdata", bus.m_wdata_o, 32'h0);
    check("arst_rdata", bus.dbg_resp_rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 32'h0000_0200, 32'h0, 2'd2, 0, 0, 32'h0BAD_F00D, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
